// File: rtl/wl_pipe_ctl_pkg.sv
// Shared definitions for the elastic pipeline controller: counter sizing
// helper and sideband bit positions.
package wl_pipe_ctl_pkg;

  // Sideband bit positions carried alongside each pixel.
  localparam int SB_SOF = 0;
  localparam int SB_EOL = 1;

  // Ceiling log2, used to size the occupancy counter at elaboration time.
  function automatic int wl_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wl_pipe_slot.sv
// One stage of the elastic chain: a valid bit and a sideband register.
// The stage loads when its source holds a pixel and it is empty or emptying.
module wl_pipe_slot #(
  parameter int SBW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           src_v,
  input  logic [SBW-1:0] src_sb,
  input  logic           mv,
  output logic           ld,
  output logic           v,
  output logic [SBW-1:0] sb
);

  logic           v_q, v_d;
  logic [SBW-1:0] sb_q, sb_d;

  // Load decision and next-state; flush and reset suppress any load.
  always_comb begin
    ld   = src_v & (~v_q | mv) & ~flush & ~rst;
    v_d  = ld | (v_q & ~mv);
    sb_d = ld ? src_sb : sb_q;
    if (flush) v_d = 1'b0;
  end

  // Stage registers; sideband is held across a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= 1'b0;
      sb_q <= '0;
    end else begin
      v_q  <= v_d;
      sb_q <= sb_d;
    end
  end

  assign v  = v_q;
  assign sb = sb_q;

endmodule

// File: rtl/wl_pipe_ctl.sv
// Elastic valid/ready controller for a chain of enable-gated datapath
// registers. Issues per-stage load enables, collapses bubbles, carries
// sideband, and tracks occupancy. The ready chain is combinational from
// out_rdy back to in_rdy.
module wl_pipe_ctl
  import wl_pipe_ctl_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int SBW   = 2,
  localparam int OCW   = wl_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [SBW-1:0]   in_sb,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [SBW-1:0]   out_sb,
  output logic [DEPTH-1:0] stg_en,
  output logic [DEPTH-1:0] stg_vld,
  output logic [OCW-1:0]   occ,
  output logic             busy
);

  logic [DEPTH-1:0] v_all;
  logic [DEPTH-1:0] ld_all;
  logic [SBW-1:0]   sb_all [DEPTH];
  logic             out_vld_int;
  logic [OCW-1:0]   occ_q, occ_d;

  assign out_vld_int = v_all[DEPTH-1] & ~flush & ~rst;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic           src_v_s, mv_s, ld_s, v_s;
    logic [SBW-1:0] src_sb_s, sb_s;

    if (i == 0) begin : g_head
      assign src_v_s  = in_vld;
      assign src_sb_s = in_sb;
    end else begin : g_body
      assign src_v_s  = v_all[i-1];
      assign src_sb_s = sb_all[i-1];
    end

    // A stage empties when the next one takes its pixel, or downstream pops.
    if (i == DEPTH - 1) begin : g_tail
      assign mv_s = out_vld_int & out_rdy;
    end else begin : g_mid
      assign mv_s = g_slot[i+1].ld_s;
    end

    wl_pipe_slot #(.SBW(SBW)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .src_v  (src_v_s),
      .src_sb (src_sb_s),
      .mv     (mv_s),
      .ld     (ld_s),
      .v      (v_s),
      .sb     (sb_s)
    );

    assign v_all[i]  = v_s;
    assign ld_all[i] = ld_s;
    assign sb_all[i] = sb_s;
  end

  assign in_rdy = (~v_all[0] | g_slot[0].mv_s) & ~flush & ~rst;

  // Occupancy follows the two handshakes; flush empties the pipe.
  always_comb begin
    occ_d = occ_q + OCW'(in_vld & in_rdy) - OCW'(out_vld_int & out_rdy);
    if (flush) occ_d = '0;
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  // Registered outputs are forced quiet while reset is held, before the
  // first reset edge has cleared the registers.
  assign out_vld = out_vld_int;
  assign out_sb  = rst ? '0 : sb_all[DEPTH-1];
  assign stg_en  = ld_all;
  assign stg_vld = rst ? '0 : v_all;
  assign occ     = rst ? '0 : occ_q;
  assign busy    = (occ != '0);

endmodule

// File: tb/tb_wl_pipe_ctl.sv
// Directed bench for wl_pipe_ctl at DEPTH=4 plus a randomised DEPTH=1
// instance checked against a queue model.
module tb_wl_pipe_ctl;
  import wl_pipe_ctl_pkg::*;

  logic       clk;
  logic       rst, flush;
  logic       in_vld, in_rdy, out_vld, out_rdy, busy;
  logic [1:0] in_sb, out_sb;
  logic [3:0] stg_en, stg_vld;
  logic [2:0] occ;

  logic       in_vld1, in_rdy1, out_vld1, out_rdy1, busy1;
  logic [1:0] in_sb1, out_sb1;
  logic [0:0] stg_en1, stg_vld1, occ1;

  int total = 0;
  int bad   = 0;

  wl_pipe_ctl #(.DEPTH(4), .SBW(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_sb(in_sb),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_sb(out_sb),
    .stg_en(stg_en), .stg_vld(stg_vld), .occ(occ), .busy(busy)
  );

  wl_pipe_ctl #(.DEPTH(1), .SBW(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld1), .in_rdy(in_rdy1), .in_sb(in_sb1),
    .out_vld(out_vld1), .out_rdy(out_rdy1), .out_sb(out_sb1),
    .stg_en(stg_en1), .stg_vld(stg_vld1), .occ(occ1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] q[$];
    int  eo, pops;
    logic exp_rdy, exp_vld;

    rst = 1; flush = 0; in_vld = 0; in_sb = 0; out_rdy = 1;
    in_vld1 = 0; in_sb1 = 0; out_rdy1 = 0;
    #2;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_occ", occ, 0);
    check("rst_stg_vld", stg_vld, 0);
    nxt(); nxt();
    in_vld = 1; #1;
    check("rst_stg_en", stg_en, 0);
    check("rst_busy", busy, 0);
    in_vld = 0;
    rst = 0; #1;
    check("post_rst_in_rdy", in_rdy, 1);
    check("post_rst_occ", occ, 0);

    // Streaming: 10 back-to-back pixels, SOF first, EOL last.
    for (int c = 0; c <= 14; c++) begin
      out_rdy = 1;
      in_vld  = (c < 10);
      in_sb   = (c == 0) ? 2'(1 << SB_SOF) : (c == 9) ? 2'(1 << SB_EOL) : 2'b00;
      #1;
      pops = (c < 4) ? 0 : ((c - 4 > 10) ? 10 : c - 4);
      eo   = ((c < 10) ? c : 10) - pops;
      check("s_in_rdy", in_rdy, 1);
      check("s_out_vld", out_vld, (c >= 4 && c <= 13));
      check("s_occ", occ, eo);
      if (c == 0) check("s_stg_en0", stg_en, 4'b0001);
      if (c >= 4 && c <= 13) check("s_out_sb", out_sb, (c == 4) ? 1 : (c == 13) ? 2 : 0);
      nxt();
    end

    // Backpressure: fill, stall 5 cycles with a pixel waiting, then release.
    for (int c = 0; c <= 14; c++) begin
      out_rdy = (c >= 9);
      in_vld  = (c <= 9);
      in_sb   = (c < 4) ? 2'(c) : 2'b00;
      #1;
      if (c < 4) check("b_fill_rdy", in_rdy, 1);
      if (c >= 4 && c <= 8) begin
        check("b_occ", occ, 4);
        check("b_in_rdy", in_rdy, 0);
        check("b_stg_en", stg_en, 4'b0000);
        check("b_out_vld", out_vld, 1);
      end
      if (c == 9) begin
        check("b_rel_rdy", in_rdy, 1);
        check("b_rel_en", stg_en, 4'b1111);
        check("b_rel_occ", occ, 4);
      end
      if (c >= 9 && c <= 13) begin
        check("b_out_vld_rel", out_vld, 1);
        check("b_out_sb", out_sb, (c - 9) % 4);
      end
      if (c >= 10) check("b_drain_occ", occ, 14 - c);
      if (c == 14) check("b_empty_vld", out_vld, 0);
      nxt();
    end

    // Bubble collapse, flush and mid-stream reset.
    for (int c = 0; c <= 20; c++) begin
      rst = 0; flush = 0; in_vld = 0; in_sb = 0; out_rdy = 0;
      case (c)
        0:  begin in_vld = 1; in_sb = 1; end
        2:  begin in_vld = 1; in_sb = 2; end
        6:  begin in_vld = 1; in_sb = 3; end
        8:  begin flush = 1; in_vld = 1; out_rdy = 1; end
        9:  begin in_vld = 1; in_sb = 2; end
        13: begin in_vld = 1; in_sb = 1; end
        14: begin rst = 1; in_vld = 1; out_rdy = 1; end
        15: begin in_vld = 1; in_sb = 3; out_rdy = 1; end
        default: out_rdy = (c >= 16);
      endcase
      #1;
      case (c)
        3: check("bc_vld3", stg_vld, 4'b0101);
        4: check("bc_vld4", stg_vld, 4'b1010);
        5: check("bc_vld5", stg_vld, 4'b1100);
        6: begin
          check("bc_vld6", stg_vld, 4'b1100);
          check("bc_occ6", occ, 2);
          check("bc_sb6", out_sb, 1);
          check("bc_rdy6", in_rdy, 1);
        end
        8: begin
          check("f_pre_occ", occ, 3);
          check("f_pre_vld", stg_vld, 4'b1110);
          check("f_in_rdy", in_rdy, 0);
          check("f_out_vld", out_vld, 0);
          check("f_stg_en", stg_en, 4'b0000);
        end
        9: begin
          check("f_post_occ", occ, 0);
          check("f_post_vld", stg_vld, 4'b0000);
          check("f_post_rdy", in_rdy, 1);
          check("f_post_busy", busy, 0);
        end
        12: check("f_lat_early", out_vld, 0);
        13: begin
          check("f_lat_vld", out_vld, 1);
          check("f_lat_sb", out_sb, 2);
          check("f_lat_occ", occ, 1);
        end
        14: begin
          check("r_in_rdy", in_rdy, 0);
          check("r_out_vld", out_vld, 0);
          check("r_stg_en", stg_en, 0);
          check("r_stg_vld", stg_vld, 0);
          check("r_occ", occ, 0);
          check("r_busy", busy, 0);
          check("r_out_sb", out_sb, 0);
        end
        15: begin
          check("r_post_occ", occ, 0);
          check("r_post_vld", stg_vld, 0);
          check("r_post_rdy", in_rdy, 1);
        end
        16, 17, 18: check("r_lat_early", out_vld, 0);
        19: begin
          check("r_lat_vld", out_vld, 1);
          check("r_lat_sb", out_sb, 3);
        end
        20: check("r_final_occ", occ, 0);
        default: ;
      endcase
      nxt();
    end
    rst = 0; flush = 0; in_vld = 0; out_rdy = 0;

    // DEPTH=1: random traffic against a one-entry queue model.
    for (int c = 0; c < 1000; c++) begin
      in_vld1  = 1'($urandom_range(0, 1));
      out_rdy1 = 1'($urandom_range(0, 1));
      in_sb1   = 2'($urandom_range(0, 3));
      #1;
      exp_vld = (q.size() != 0);
      exp_rdy = (q.size() == 0) || out_rdy1;
      check("d1_in_rdy", in_rdy1, exp_rdy);
      check("d1_out_vld", out_vld1, exp_vld);
      check("d1_stg_en", stg_en1, in_vld1 & exp_rdy);
      check("d1_occ", occ1, q.size());
      check("d1_occ_pop", occ1, stg_vld1);
      if (exp_vld) check("d1_out_sb", out_sb1, q[0]);
      if (exp_vld && out_rdy1) void'(q.pop_front());
      if (in_vld1 && exp_rdy) q.push_back(in_sb1);
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
